// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - object entry layout, scan states and draw-command type shared by scanner and renderer
package obj_pkg;

  localparam int OBJ_COUNT = 256;

  // word0
  localparam int Y_LSB      = 0;
  localparam int Y_W        = 9;
  localparam int HEIGHT_LSB = 9;
  localparam int HEIGHT_W   = 2;
  localparam int LAYER_LSB  = 13;
  localparam int LAYER_W    = 3;
  // word1
  localparam int CODE_LSB   = 0;
  localparam int CODE_W     = 16;
  // word2
  localparam int COLOR_LSB  = 0;
  localparam int COLOR_W    = 7;
  localparam int FLIPX_BIT  = 8;
  localparam int FLIPY_BIT  = 9;
  // word3
  localparam int X_LSB      = 0;
  localparam int X_W        = 10;

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, EVAL, EMIT
  } scan_state_t;

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic [3:0]         row;
    logic [X_W-1:0]     x;
    logic [COLOR_W-1:0] color;
    logic               flipx;
    logic [LAYER_W-1:0] layer;
  } draw_cmd_t;

endpackage

// File: rtl/obj_row_calc.sv
// rtl/obj_row_calc.sv - object visibility test and tile code/row selection for one scanline
module obj_row_calc
  import obj_pkg::*;
(
  input  logic [Y_W-1:0]      line,
  input  logic [Y_W-1:0]      y,
  input  logic [HEIGHT_W-1:0] height,
  input  logic                flipy,
  input  logic [CODE_W-1:0]   code,
  output logic                visible,
  output logic [CODE_W-1:0]   code_out,
  output logic [3:0]          row_out
);

  logic [Y_W-1:0] row;
  logic [6:0]     span_m1;
  logic [6:0]     eff_row;

  always_comb begin
    row = line - y;
    case (height)
      2'd0:    span_m1 = 7'd15;
      2'd1:    span_m1 = 7'd31;
      2'd2:    span_m1 = 7'd63;
      default: span_m1 = 7'd127;
    endcase
    visible  = (row <= {2'b00, span_m1});
    // Only row[6:0] matters once visible; tiles stack vertically as code+0..7.
    eff_row  = flipy ? (span_m1 - row[6:0]) : row[6:0];
    code_out = code + {13'd0, eff_row[6:4]};
    row_out  = eff_row[3:0];
  end

endmodule

// File: rtl/obj_line_scanner.sv
// rtl/obj_line_scanner.sv - scans 256 object entries per line and emits draw commands for visible ones
// Optional macro OBJ_SCAN_LIMIT_EN caps accepted commands per line at MAX_PER_LINE and raises overflow.
module obj_line_scanner
  import obj_pkg::*;
#(
  parameter int MAX_PER_LINE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        line_start,
  input  logic [8:0]  line,
  output logic [9:0]  obj_addr,
  input  logic [15:0] obj_din,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [15:0] cmd_code,
  output logic [3:0]  cmd_row,
  output logic [9:0]  cmd_x,
  output logic [6:0]  cmd_color,
  output logic        cmd_flipx,
  output logic [2:0]  cmd_layer,
  output logic        busy,
  output logic        overflow
);

  scan_state_t         state, state_next;
  logic [7:0]          idx;
  logic [Y_W-1:0]      line_q;
  logic [Y_W-1:0]      y_q;
  logic [HEIGHT_W-1:0] height_q;
  logic [LAYER_W-1:0]  layer_q;
  logic [CODE_W-1:0]   code_q;
  logic [COLOR_W-1:0]  color_q;
  logic                flipx_q;
  logic                flipy_q;
  draw_cmd_t           cmd_q;

  logic                visible;
  logic [CODE_W-1:0]   calc_code;
  logic [3:0]          calc_row;
  logic                last_obj;
  logic                limit_hit;
  logic [1:0]          word_sel;

  obj_row_calc u_row_calc (
    .line     (line_q),
    .y        (y_q),
    .height   (height_q),
    .flipy    (flipy_q),
    .code     (code_q),
    .visible  (visible),
    .code_out (calc_code),
    .row_out  (calc_row)
  );

  assign last_obj = (idx == 8'(OBJ_COUNT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ce) begin
      if (line_start) begin
        state_next = RD0;
      end else begin
        case (state)
          RD0:     state_next = RD1;
          RD1:     state_next = RD2;
          RD2:     state_next = RD3;
          RD3:     state_next = EVAL;
          EVAL:    state_next = visible ? EMIT : (last_obj ? IDLE : RD0);
          EMIT:    if (cmd_ready) state_next = (last_obj || limit_hit) ? IDLE : RD0;
          default: state_next = state;
        endcase
      end
    end
  end

  always_comb begin
    case (state)
      RD1:     word_sel = 2'd1;
      RD2:     word_sel = 2'd2;
      RD3:     word_sel = 2'd3;
      default: word_sel = 2'd0;
    endcase
  end

  // Word n-1 is on obj_din while the address for word n is being presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      line_q   <= '0;
      y_q      <= '0;
      height_q <= '0;
      layer_q  <= '0;
      code_q   <= '0;
      color_q  <= '0;
      flipx_q  <= 1'b0;
      flipy_q  <= 1'b0;
      cmd_q    <= '0;
    end else if (ce) begin
      if (line_start) begin
        line_q <= line;
        idx    <= '0;
      end else begin
        case (state)
          RD1: begin
            y_q      <= obj_din[Y_LSB +: Y_W];
            height_q <= obj_din[HEIGHT_LSB +: HEIGHT_W];
            layer_q  <= obj_din[LAYER_LSB +: LAYER_W];
          end
          RD2: code_q <= obj_din[CODE_LSB +: CODE_W];
          RD3: begin
            color_q <= obj_din[COLOR_LSB +: COLOR_W];
            flipx_q <= obj_din[FLIPX_BIT];
            flipy_q <= obj_din[FLIPY_BIT];
          end
          EVAL: begin
            if (visible)
              cmd_q <= '{code: calc_code, row: calc_row, x: obj_din[X_LSB +: X_W],
                         color: color_q, flipx: flipx_q, layer: layer_q};
            else if (!last_obj)
              idx <= idx + 8'd1;
          end
          EMIT: if (cmd_ready && !last_obj) idx <= idx + 8'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef OBJ_SCAN_LIMIT_EN
  logic [8:0] cmd_count;
  logic       overflow_q;

  assign limit_hit = (cmd_count == 9'(MAX_PER_LINE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_count  <= '0;
      overflow_q <= 1'b0;
    end else if (ce) begin
      if (line_start) begin
        cmd_count  <= '0;
        overflow_q <= 1'b0;
      end else if (state == EMIT && cmd_ready) begin
        cmd_count <= cmd_count + 9'd1;
        if (limit_hit) overflow_q <= 1'b1;
      end
    end
  end

  assign overflow = overflow_q;
`else
  assign limit_hit = 1'b0;
  assign overflow  = 1'b0;
`endif

  // An abort withdraws a pending command in the same cycle so it can never transfer.
  assign cmd_valid = (state == EMIT) && !(ce && line_start);
  assign obj_addr  = {idx, word_sel};
  assign busy      = (state != IDLE);
  assign cmd_code  = cmd_q.code;
  assign cmd_row   = cmd_q.row;
  assign cmd_x     = cmd_q.x;
  assign cmd_color = cmd_q.color;
  assign cmd_flipx = cmd_q.flipx;
  assign cmd_layer = cmd_q.layer;

endmodule
